// File: rtl/sub_64_pipe.sv
// sub_64_pipe: 64-bit pipelined subtractor, diff = in1 - in2 - bin.
// Four borrow-ripple slices, one per pipeline stage, with the borrow
// forwarded stage to stage. Valid/ready on both sides; bubbles collapse
// so up to four results can be held while the consumer stalls.
module sub_64_pipe #(
  parameter int SLICE_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in1,
  input  logic [63:0] in2,
  input  logic        bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] diff,
  output logic        bout,
  output logic        ovf
);

  // {borrow, difference} of one slice; the extra top bit absorbs the case
  // where the subtrahend plus borrow-in reaches 2^SLICE_W.
  function automatic logic [SLICE_W:0] sub_slice(input logic [SLICE_W-1:0] a,
                                                 input logic [SLICE_W-1:0] b,
                                                 input logic             bi);
    sub_slice = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, bi};
  endfunction

  // Signed overflow of a - b: operand signs differ and the result sign
  // does not follow the minuend.
  function automatic logic ovf_flag(input logic sa, input logic sb, input logic sd);
    ovf_flag = (sa != sb) && (sd != sa);
  endfunction

  // Stage valids and advance enables
  logic vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;
  logic adv_p0, adv_p1, adv_p2, adv_p3;

  // Stage 0: slice 0 result, operands for slices 1..3
  logic [SLICE_W-1:0]   res_p0_q;
  logic                 brw_p0_q;
  logic [3*SLICE_W-1:0] opa_p0_q, opb_p0_q;

  // Stage 1: slices 0..1 result, operands for slices 2..3
  logic [2*SLICE_W-1:0] res_p1_q;
  logic                 brw_p1_q;
  logic [2*SLICE_W-1:0] opa_p1_q, opb_p1_q;

  // Stage 2: slices 0..2 result, operands for slice 3 (holds both sign bits)
  logic [3*SLICE_W-1:0] res_p2_q;
  logic                 brw_p2_q;
  logic [SLICE_W-1:0]   opa_p2_q, opb_p2_q;

  // Stage 3: finished result
  logic [63:0] diff_q;
  logic        bout_q;
  logic        ovf_q;

  // Slice arithmetic feeding each stage
  logic [SLICE_W:0] sl_p0_d, sl_p1_d, sl_p2_d, sl_p3_d;

  // Advance chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    adv_p3 = ~vld_p3_q | out_ready;
    adv_p2 = ~vld_p2_q | adv_p3;
    adv_p1 = ~vld_p1_q | adv_p2;
    adv_p0 = ~vld_p0_q | adv_p1;
  end

  // One 16-bit borrow-ripple subtract per stage, chained through stored borrows.
  always_comb begin
    sl_p0_d = sub_slice(in1[SLICE_W-1:0], in2[SLICE_W-1:0], bin);
    sl_p1_d = sub_slice(opa_p0_q[SLICE_W-1:0], opb_p0_q[SLICE_W-1:0], brw_p0_q);
    sl_p2_d = sub_slice(opa_p1_q[SLICE_W-1:0], opb_p1_q[SLICE_W-1:0], brw_p1_q);
    sl_p3_d = sub_slice(opa_p2_q, opb_p2_q, brw_p2_q);
  end

  // Valid bits follow their data forward whenever the stage advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      if (adv_p0) vld_p0_q <= in_valid;
      if (adv_p1) vld_p1_q <= vld_p0_q;
      if (adv_p2) vld_p2_q <= vld_p1_q;
      if (adv_p3) vld_p3_q <= vld_p2_q;
    end
  end

  // ---- stage 0 boundary ----
  // Capture slice 0 and park the remaining operand slices.
  always_ff @(posedge clk) begin
    if (adv_p0 && in_valid) begin
      res_p0_q <= sl_p0_d[SLICE_W-1:0];
      brw_p0_q <= sl_p0_d[SLICE_W];
      opa_p0_q <= in1[63:SLICE_W];
      opb_p0_q <= in2[63:SLICE_W];
    end
  end

  // ---- stage 1 boundary ----
  // Append slice 1 and drop the consumed operand slice.
  always_ff @(posedge clk) begin
    if (adv_p1 && vld_p0_q) begin
      res_p1_q <= {sl_p1_d[SLICE_W-1:0], res_p0_q};
      brw_p1_q <= sl_p1_d[SLICE_W];
      opa_p1_q <= opa_p0_q[3*SLICE_W-1:SLICE_W];
      opb_p1_q <= opb_p0_q[3*SLICE_W-1:SLICE_W];
    end
  end

  // ---- stage 2 boundary ----
  // Append slice 2; the top slice operands carry in1[63]/in2[63] onward.
  always_ff @(posedge clk) begin
    if (adv_p2 && vld_p1_q) begin
      res_p2_q <= {sl_p2_d[SLICE_W-1:0], res_p1_q};
      brw_p2_q <= sl_p2_d[SLICE_W];
      opa_p2_q <= opa_p1_q[2*SLICE_W-1:SLICE_W];
      opb_p2_q <= opb_p1_q[2*SLICE_W-1:SLICE_W];
    end
  end

  // ---- stage 3 boundary ----
  // Final slice, borrow-out and overflow; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= 64'd0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (adv_p3 && vld_p2_q) begin
      diff_q <= {sl_p3_d[SLICE_W-1:0], res_p2_q};
      bout_q <= sl_p3_d[SLICE_W];
      ovf_q  <= ovf_flag(opa_p2_q[SLICE_W-1], opb_p2_q[SLICE_W-1], sl_p3_d[SLICE_W-1]);
    end
  end

  assign in_ready  = adv_p0;
  assign out_valid = vld_p3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_64_pipe.sv
// Directed testbench for sub_64_pipe.
module tb_sub_64_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        bin = 1'b0;
  logic [63:0] in1 = 64'd0;
  logic [63:0] in2 = 64'd0;
  logic        in_ready, out_valid, bout, ovf;
  logic [63:0] diff;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  sub_64_pipe #(.SLICE_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: 65-bit subtraction, packed as {bout, ovf, diff}.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic bi);
    logic [64:0] t;
    logic        ov;
    t  = {1'b0, a} - {1'b0, b} - 65'(bi);
    ov = (a[63] != b[63]) && (t[63] != a[63]);
    return {t[64], ov, t[63:0]};
  endfunction

  // One isolated transaction with out_ready high; checks latency and result.
  task automatic run_one(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic bi, input logic [63:0] ed, input logic eb,
                         input logic eo);
    int n;
    in1 = a; in2 = b; bin = bi; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 66'(in_ready), 66'(1));
    tick;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    chk({tag, "_latency"}, 66'(n), 66'(4));
    chk({tag, "_result"}, {bout, ovf, diff}, {eb, eo, ed});
    tick;
  endtask

  logic [63:0] va [16];
  logic [63:0] vb [16];
  logic        vbi[16];
  logic [65:0] expq[$];
  logic [65:0] held;
  logic [65:0] front;
  logic        stalled;
  int          inflight, sent, rcvd, cyc;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 66'(out_valid), 66'(0));
    chk("rst_in_ready", 66'(in_ready), 66'(1));
    chk("rst_outputs", {bout, ovf, diff}, 66'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("post_rst_out_valid", 66'(out_valid), 66'(0));

    // Directed vectors
    run_one("basic", 64'd5, 64'd3, 1'b0 | 1'b1, 64'd1, 1'b0, 1'b0);
    run_one("wrap", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_one("xslice", 64'h0000_0001_0000_0000, 64'd1, 1'b0,
            64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0);
    run_one("full_borrow", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'd0, 1'b1, 1'b0);
    run_one("sovf_neg", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_one("sovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b1, 1'b1);

    // Random stream with random backpressure
    for (int i = 0; i < 16; i++) begin
      va[i]  = {$urandom, $urandom};
      vb[i]  = {$urandom, $urandom};
      vbi[i] = 1'($urandom_range(0, 1));
    end
    inflight = 0; sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = 66'd0;
    while (rcvd < 16 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 16) begin
        in_valid = 1'b1; in1 = va[sent]; in2 = vb[sent]; bin = vbi[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 66'(in_ready), 66'(!(inflight == 4 && !out_ready)));
      if (stalled) begin
        chk("bp_hold_valid", 66'(out_valid), 66'(1));
        chk("bp_hold_data", {bout, ovf, diff}, held);
      end
      if (out_valid && out_ready) begin
        if (expq.size() > 0) begin
          front = expq.pop_front();
          chk("bp_result", {bout, ovf, diff}, front);
        end else begin
          chk("bp_extra_result", 66'(expq.size()), 66'(1));
        end
        rcvd++;
        inflight--;
      end
      stalled = out_valid && !out_ready;
      held    = {bout, ovf, diff};
      if (in_valid && in_ready) begin
        expq.push_back(model(in1, in2, bin));
        sent++;
        inflight++;
      end
      tick;
      cyc++;
    end
    chk("bp_received", 66'(rcvd), 66'(16));
    chk("bp_queue_empty", 66'(expq.size()), 66'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    tick; tick; tick;
    chk("bp_no_dup", 66'(out_valid), 66'(0));

    // Reset mid-flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in1 = va[i]; in2 = vb[i]; bin = vbi[i];
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("mid_pre_valid", 66'(out_valid), 66'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 66'(out_valid), 66'(0));
    chk("mid_rst_outputs", {bout, ovf, diff}, 66'(0));
    chk("mid_rst_in_ready", 66'(in_ready), 66'(1));
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick;
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_stale", 66'(out_valid), 66'(0));
      tick;
    end
    chk("mid_in_ready", 66'(in_ready), 66'(1));
    run_one("after_rst", 64'd5, 64'd3, 1'b1, 64'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sub_64_pipe.md
Name: sub_64_pipe

Overview:
- Pipelined 64-bit subtractor: diff = in1 - in2 - bin. It is the inverse-direction companion to the team's 64-bit ripple adder.
- Built from four 16-bit borrow-ripple slices, one slice per pipeline stage, with the borrow forwarded stage to stage.
- Valid/ready handshake on both sides. Sits on the datapath where adder results are un-done (difference/compare paths) at full clock rate.

Parameters:
- SLICE_W, 16, bits per pipeline stage; fixed at 16. Stage count = 64/SLICE_W = 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- in1  input  64  minuend (unsigned / two's complement)
- in2  input  64  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- diff  output  64  (in1 - in2 - bin) mod 2^64
- bout  output  1  borrow-out: 1 iff in1 < in2 + bin (unsigned)
- ovf  output  1  signed overflow: in1[63] != in2[63] and diff[63] != in1[63]

Behaviour:
- One clock domain. rst_n asynchronous active-low, synchronous deassertion is the integrator's responsibility.
- Reset values:
  - all stage valid bits v[0..3] = 0, so out_valid = 0
  - diff = 0, bout = 0, ovf = 0
  - in_ready = 1 after reset (combinational from v)
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - diff/bout/ovf are held stable while out_valid & ~out_ready.
- Stage k (k = 0..3) holds:
  - valid v[k]
  - result slices 0..k of diff
  - borrow b[k] out of slice k
  - unconsumed operand slices k+1..3 of in1/in2
  - in1[63] and in2[63] for ovf
- Load/advance rules (bubble-collapsing):
  - adv[3] = ~v[3] | out_ready
  - adv[k] = ~v[k] | adv[k+1], for k < 3
  - in_ready = adv[0]
  - Stage k captures stage k-1 (stage 0 captures input) when adv[k].
  - On that edge, v[k] <= v[k-1] (stage 0: v[0] <= in_valid).
- Slice arithmetic: {b_k, d_k} = {1'b0, A_k} - {1'b0, B_k} - b_(k-1), 17-bit, with b_(-1) = bin. b_k = 1 iff A_k < B_k + b_(k-1).
- Output mapping: bout = b[3] of stage 3. ovf is computed in stage 3 from the carried sign bits and diff[63]. out_valid = v[3].
- Latency: 4 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle sustained.
- Backpressure:
  - With out_ready = 0 and all 4 stages full, in_ready = 0.
  - Bubbles collapse: with out_ready held 0, up to 4 results accumulate before in_ready drops.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with the pipe full: both occur, occupancy unchanged.
  - No transaction is lost or duplicated, and order is preserved.
- Reset mid-operation: all in-flight results are discarded and v cleared immediately (asynchronous). After reset no stale out_valid appears.
- Boundary cases:
  - in2 + bin = 2^64 (in2 = all-ones, bin = 1) is handled by the 17-bit slice math.
  - Example: in1 = 0 gives diff = 0, bout = 1.
- Area: no multipliers. Only four 16-bit subtractors plus pipeline registers.

Test Plan:
- Basic: in1=5, in2=3, bin=1 -> after 4 cycles out_valid=1, diff=0x1, bout=0, ovf=0.
- Full wrap: in1=0, in2=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0.
- Cross-slice borrow: in1=0x0000_0001_0000_0000, in2=0x1, bin=0 -> diff=0x0000_0000_FFFF_FFFF, bout=0. Then in1=0, in2=0xFFFF_FFFF_FFFF_FFFF, bin=1 -> diff=0, bout=1.
- Signed overflow: in1=0x8000_0000_0000_0000, in2=1, bin=0 -> diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
- Backpressure:
  - Stream 16 random vectors with in_valid=1 and out_ready random (~50%).
  - Required: results match a reference model in order with no loss or duplication.
  - Required: in_ready=0 exactly when 4 stages are full and out_ready=0.
  - Required: outputs stable while stalled.
- Reset mid-flight: load 3 vectors, assert rst_n=0 asynchronously between edges -> out_valid=0, diff=0 immediately. After release, in_ready=1 and no stale outputs appear.
